vz_ram_arbiter: RTL and testbench

// Shares the single system-RAM write port between the Z80 CPU and the VZ program loader.

---
 rtl/vz_pkg.sv | 23 ++
 rtl/vz_wr_fifo.sv | 52 +++++
 rtl/vz_ram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_vz_ram_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vz_pkg.sv
// Shared types for the VZ loader / CPU RAM write-port arbiter.
package vz_pkg;

  localparam int RAM_AW = 16;
  localparam int ENT_W  = RAM_AW + 8;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LDR = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DRAIN,
    FIRE
  } exec_state_t;

  typedef struct packed {
    logic [RAM_AW-1:0] addr;
    logic [7:0]        data;
  } ld_ent_t;

endpackage

// File: rtl/vz_wr_fifo.sv
// Loader write buffer: DEPTH x W synchronous FIFO, pointers wrap mod DEPTH.
module vz_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          do_push;
  logic          do_pop;

  // A full FIFO refuses the push even when a pop frees a slot.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      if (do_push & ~do_pop)
        count <= count + 1'b1;
      else if (do_pop & ~do_push)
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/vz_ram_arbiter.sv
// Shares the RAM write port between the Z80 and the VZ loader,
// and releases the loader's execute request once the download drains.
module vz_ram_arbiter
  import vz_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_DEFER = 8
) (
  input  logic              CPU_CLOCK,
  input  logic              I_RST,
  input  logic              dl_active,
  input  logic              ld_wr,
  input  logic [RAM_AW-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  output logic              ld_overflow,
  input  logic              ld_exec_req,
  input  logic [RAM_AW-1:0] ld_exec_addr,
  input  logic              cpu_req,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_wait,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_owner,
  output logic              exec_strobe,
  output logic [RAM_AW-1:0] exec_addr
);

  localparam int CW = $clog2(DEPTH);
  localparam int DW = $clog2(MAX_DEFER);
  localparam logic [CW:0]   CNT_FULL = (CW+1)'(DEPTH);
  localparam logic [DW-1:0] DEF_MAX  = DW'(MAX_DEFER - 1);

  ld_ent_t           in_ent;
  ld_ent_t           head;
  logic              full;
  logic              empty;
  logic [CW:0]       cnt;
  logic              ldr_gnt;
  logic              cpu_gnt;
  logic              forced;
  logic [DW-1:0]     defer;
  logic              req_q;
  logic              req_rise;
  logic              exec_pend;
  logic [RAM_AW-1:0] pend_addr;
  logic              drained;
  exec_state_t       st;
  exec_state_t       st_nxt;

  assign in_ent   = '{addr: ld_addr, data: ld_data};
  assign ld_ready = (cnt != CNT_FULL);

  vz_wr_fifo #(
    .DEPTH (DEPTH),
    .W     (ENT_W)
  ) u_fifo (
    .clk   (CPU_CLOCK),
    .rst   (I_RST),
    .push  (ld_wr),
    .pop   (ldr_gnt),
    .wdata (in_ent),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  assign forced = ~dl_active & ~empty & (defer == DEF_MAX);

  always_comb begin
    ldr_gnt  = 1'b0;
    cpu_gnt  = 1'b0;
    cpu_wait = 1'b0;
    if (dl_active) begin
      cpu_wait = 1'b1;
      ldr_gnt  = ~empty;
    end else if (forced) begin
      cpu_wait = 1'b1;
      ldr_gnt  = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt  = 1'b1;
    end else begin
      ldr_gnt  = ~empty;
    end
  end

  always_ff @(posedge CPU_CLOCK) begin
    if (I_RST) begin
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_owner <= OWN_CPU;
    end else begin
      ram_we <= ldr_gnt | cpu_gnt;
      if (ldr_gnt) begin
        ram_addr  <= head.addr;
        ram_wdata <= head.data;
        ram_owner <= OWN_LDR;
      end else if (cpu_gnt) begin
        ram_addr  <= cpu_addr;
        ram_wdata <= cpu_wdata;
        ram_owner <= OWN_CPU;
      end
    end
  end

  always_ff @(posedge CPU_CLOCK) begin
    if (I_RST) begin
      ld_overflow <= 1'b0;
    end else if (ld_wr & full) begin
      ld_overflow <= 1'b1;
    end
  end

  always_ff @(posedge CPU_CLOCK) begin
    if (I_RST | empty | ldr_gnt) begin
      defer <= '0;
    end else if (cpu_gnt && defer != DEF_MAX) begin
      defer <= defer + 1'b1;
    end
  end

  assign req_rise = ld_exec_req & ~req_q;
  // The last loader write lands on the same edge FIRE begins.
  assign drained  = ~dl_active & empty;

  always_ff @(posedge CPU_CLOCK) begin
    if (I_RST) begin
      req_q     <= 1'b0;
      exec_pend <= 1'b0;
      pend_addr <= '0;
    end else begin
      req_q <= ld_exec_req;
      if (req_rise) begin
        exec_pend <= 1'b1;
        pend_addr <= ld_exec_addr;
      end else if (st == FIRE) begin
        exec_pend <= 1'b0;
      end
    end
  end

  always_ff @(posedge CPU_CLOCK) begin
    if (I_RST) begin
      st        <= IDLE;
      exec_addr <= '0;
    end else begin
      st <= st_nxt;
      if (st == WAIT_DRAIN && drained)
        exec_addr <= pend_addr;
    end
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      IDLE:       if (exec_pend) st_nxt = WAIT_DRAIN;
      WAIT_DRAIN: if (drained)   st_nxt = FIRE;
      FIRE:       st_nxt = IDLE;
      default:    st_nxt = IDLE;
    endcase
  end

  assign exec_strobe = (st == FIRE);

endmodule

// File: tb/tb_vz_ram_arbiter.sv
// Self-checking bench for vz_ram_arbiter: cycle model plus
// directed scenarios with literal expectations.
module tb_vz_ram_arbiter;

  localparam int DEPTH = 4;
  localparam int MAXD  = 8;

  logic        clk = 1'b0;
  logic        I_RST;
  logic        dl_active;
  logic        ld_wr;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;
  logic        ld_ready;
  logic        ld_overflow;
  logic        ld_exec_req;
  logic [15:0] ld_exec_addr;
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wait;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_owner;
  logic        exec_strobe;
  logic [15:0] exec_addr;

  always #5 clk = ~clk;

  vz_ram_arbiter #(
    .DEPTH     (DEPTH),
    .MAX_DEFER (MAXD)
  ) dut (
    .CPU_CLOCK    (clk),
    .I_RST        (I_RST),
    .dl_active    (dl_active),
    .ld_wr        (ld_wr),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .ld_overflow  (ld_overflow),
    .ld_exec_req  (ld_exec_req),
    .ld_exec_addr (ld_exec_addr),
    .cpu_req      (cpu_req),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_wait     (cpu_wait),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_owner    (ram_owner),
    .exec_strobe  (exec_strobe),
    .exec_addr    (exec_addr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int       cyc;
    bit       own;
    bit [15:0] addr;
    bit [7:0]  data;
  } wr_t;

  wr_t wlog[$];
  int  strobes    = 0;
  int  strobe_cyc = -1;
  int  wait_hi    = 0;
  int  wait_lo    = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Behavioural model: queue-based FIFO and rule-level grant.
  bit [23:0] mq[$];
  int        mdef   = 0;
  bit        movf   = 0;
  bit        mwe    = 0;
  bit        mown   = 0;
  bit [15:0] maddr  = 0;
  bit [7:0]  mdata  = 0;
  bit        mreq_q = 0;
  bit        mpend  = 0;
  bit [15:0] mpaddr = 0;
  bit [15:0] meaddr = 0;
  int        mst    = 0;
  bit        mvalid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin : mdl
    bit ne, frc, lg, cg, drn, rise, full;
    int nst;
    if (I_RST) begin
      mq.delete();
      mdef = 0; movf = 0; mwe = 0; mown = 0;
      maddr = 0; mdata = 0; mreq_q = 0; mpend = 0;
      mpaddr = 0; meaddr = 0; mst = 0; mvalid = 1;
    end else begin
      ne   = (mq.size() != 0);
      full = (mq.size() == DEPTH);
      frc  = !dl_active && ne && mdef == MAXD - 1;
      lg   = dl_active ? ne : frc ? 1'b1 : cpu_req ? 1'b0 : ne;
      cg   = !dl_active && !frc && cpu_req;
      mwe  = lg || cg;
      if (lg) begin
        {maddr, mdata} = mq[0];
        mown = 1;
      end else if (cg) begin
        maddr = cpu_addr; mdata = cpu_wdata; mown = 0;
      end
      if (!ne || lg) mdef = 0;
      else if (cg && mdef < MAXD - 1) mdef++;
      drn  = !dl_active && !ne;
      rise = ld_exec_req && !mreq_q;
      nst  = (mst == 0) ? (mpend ? 1 : 0) :
             (mst == 1) ? (drn ? 2 : 1) : 0;
      if (mst == 1 && drn) meaddr = mpaddr;
      if (rise) begin
        mpend = 1; mpaddr = ld_exec_addr;
      end else if (mst == 2) begin
        mpend = 0;
      end
      mst    = nst;
      mreq_q = ld_exec_req;
      if (lg) void'(mq.pop_front());
      if (ld_wr) begin
        if (full) movf = 1;
        else mq.push_back({ld_addr, ld_data});
      end
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      check("ram_we", ram_we, mwe);
      if (mwe) begin
        check("ram_addr", ram_addr, maddr);
        check("ram_wdata", ram_wdata, mdata);
        check("ram_owner", ram_owner, mown);
      end
      check("cpu_wait", cpu_wait,
            dl_active || (mdef == MAXD - 1 && mq.size() != 0));
      check("ld_ready", ld_ready, mq.size() < DEPTH);
      check("ld_overflow", ld_overflow, movf);
      check("exec_strobe", exec_strobe, mst == 2);
      check("exec_addr", exec_addr, meaddr);
    end
    if (ram_we === 1'b1)
      wlog.push_back('{cyc, ram_owner, ram_addr, ram_wdata});
    if (exec_strobe === 1'b1) begin
      strobes++;
      strobe_cyc = cyc;
    end
    if (cpu_wait === 1'b1) wait_hi++;
    else wait_lo++;
  end

  function automatic int n_ldr();
    int n = 0;
    foreach (wlog[i]) if (wlog[i].own) n++;
    return n;
  endfunction

  function automatic logic [31:0] ldr_fld(int n, bit want_cyc);
    int k = 0;
    foreach (wlog[i]) begin
      if (wlog[i].own) begin
        if (k == n) return want_cyc ? wlog[i].cyc : 32'(wlog[i].addr);
        k++;
      end
    end
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int own_at(int c);
    foreach (wlog[i]) if (wlog[i].cyc == c) return int'(wlog[i].own);
    return 2;
  endfunction

  function automatic int n_cpu(int lo, int hi);
    int n = 0;
    foreach (wlog[i])
      if (!wlog[i].own && wlog[i].cyc >= lo && wlog[i].cyc <= hi) n++;
    return n;
  endfunction

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(logic [15:0] a, logic [7:0] d);
    ld_wr = 1'b1; ld_addr = a; ld_data = d;
    step(1);
  endtask

  int push_cyc, lp, drop_cyc, rst_cyc, post;

  initial begin
    I_RST = 1'b1; dl_active = 1'b0; ld_wr = 1'b0;
    ld_addr = '0; ld_data = '0; ld_exec_req = 1'b0;
    ld_exec_addr = '0; cpu_req = 1'b0; cpu_addr = '0;
    cpu_wdata = '0;
    step(2);
    I_RST = 1'b0;
    check("rst_ld_ready", ld_ready, 1);
    check("rst_ram_we", ram_we, 0);
    check("rst_strobe", exec_strobe, 0);
    check("rst_ovf", ld_overflow, 0);

    // Download: CPU held off, four loader bytes in order
    wlog.delete(); wait_lo = 0;
    dl_active = 1'b1; cpu_req = 1'b1;
    cpu_addr = 16'h2000; cpu_wdata = 8'h11;
    for (int i = 0; i < 4; i++) push(16'h7AE9 + 16'(i), 8'hA0 + 8'(i));
    ld_wr = 1'b0;
    step(4);
    check("dl_nwrites", wlog.size(), 4);
    for (int i = 0; i < 4; i++)
      check("dl_order", ldr_fld(i, 0), 32'h7AE9 + 32'(i));
    check("dl_cpu_wait_low", wait_lo, 0);
    dl_active = 1'b0; cpu_req = 1'b0;
    step(2);

    // Starvation: one entry behind continuous CPU traffic
    cpu_req = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 8'h22;
    step(1);
    wlog.delete(); wait_hi = 0; push_cyc = cyc;
    push(16'h4444, 8'h44);
    ld_wr = 1'b0;
    step(11);
    check("starve_cpu7", n_cpu(push_cyc + 2, push_cyc + 8), 7);
    check("starve_ldr_cyc", ldr_fld(0, 1), push_cyc + 9);
    check("starve_ldr_addr", ldr_fld(0, 0), 32'h4444);
    check("starve_resume", own_at(push_cyc + 10), 0);
    check("starve_wait1", wait_hi, 1);
    cpu_req = 1'b0;
    step(2);

    // Push and pop together at count 2 across the pointer wrap
    wlog.delete();
    cpu_req = 1'b1; cpu_addr = 16'h5000;
    push(16'h6000, 8'h60);
    push(16'h6001, 8'h61);
    dl_active = 1'b1; cpu_req = 1'b0;
    for (int i = 2; i < 6; i++) begin
      lp = cyc;
      push(16'h6000 + 16'(i), 8'h60 + 8'(i));
    end
    ld_wr = 1'b0;
    step(4);
    dl_active = 1'b0;
    check("pp_nldr", n_ldr(), 6);
    for (int i = 0; i < 6; i++)
      check("pp_order", ldr_fld(i, 0), 32'h6000 + 32'(i));
    check("pp_last_cyc", ldr_fld(5, 1), lp + 3);
    step(2);

    // Exec request behind two pending download bytes
    wlog.delete(); strobes = 0;
    dl_active = 1'b1;
    push(16'h9000, 8'h90);
    ld_exec_req = 1'b1; ld_exec_addr = 16'h7AE9;
    push(16'h9001, 8'h91);
    ld_wr = 1'b0; ld_exec_req = 1'b0;
    step(4);
    drop_cyc = cyc; dl_active = 1'b0;
    step(6);
    check("exec_count", strobes, 1);
    check("exec_when", strobe_cyc, drop_cyc + 1);
    check("exec_after_wr", strobe_cyc > int'(ldr_fld(1, 1)), 1);
    check("exec_nldr", n_ldr(), 2);
    check("exec_addr_lit", exec_addr, 16'h7AE9);

    // Overflow: six pushes while the CPU holds the port
    wlog.delete();
    cpu_req = 1'b1; cpu_addr = 16'h2222;
    for (int i = 0; i < 6; i++) push(16'h8000 + 16'(i), 8'h80 + 8'(i));
    ld_wr = 1'b0;
    check("ovf_flag", ld_overflow, 1);
    check("ovf_full", ld_ready, 0);
    dl_active = 1'b1; cpu_req = 1'b0;
    step(6);
    check("ovf_nldr", n_ldr(), 4);
    for (int i = 0; i < 4; i++)
      check("ovf_order", ldr_fld(i, 0), 32'h8000 + 32'(i));
    dl_active = 1'b0;
    step(2);

    // Reset with three queued entries and a pending exec
    strobes = 0;
    cpu_req = 1'b1; cpu_addr = 16'h1000;
    push(16'hA000, 8'h01);
    push(16'hA001, 8'h02);
    ld_exec_req = 1'b1; ld_exec_addr = 16'h1111;
    push(16'hA002, 8'h03);
    ld_wr = 1'b0; ld_exec_req = 1'b0; cpu_req = 1'b0;
    I_RST = 1'b1; rst_cyc = cyc;
    step(1);
    I_RST = 1'b0;
    step(15);
    post = 0;
    foreach (wlog[i]) if (wlog[i].cyc > rst_cyc) post++;
    check("rst_no_writes", post, 0);
    check("rst_ready", ld_ready, 1);
    check("rst_no_strobe", strobes, 0);
    check("rst_exec_addr", exec_addr, 0);
    check("rst_ovf_clr", ld_overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
